// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer. It runs a req/ack handshake with a
// multi-cycle data memory and holds the whole pipeline frozen until the
// access completes. Misaligned or unanswered accesses produce a one-cycle
// error pulse instead of wedging the pipeline.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 256   // max REQ cycles without ack, 1..65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // memory control bits from EX/MEM
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    // pipeline freeze
    output logic        stall_o,
    // data memory handshake
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    // towards MEM/WB
    output logic [31:0] rdata_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 16 bits covers the largest legal TIMEOUT (counter tops out at TIMEOUT-1)
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_acc;
    logic        w_aligned;
    logic        w_start;
    logic        w_misalign;
    logic        w_tmo;

    // Access decode: a read+write combination is issued as a write
    assign w_acc      = MemRead_i | MemWrite_i;
    assign w_aligned  = (addr_i[1:0] == 2'b00);
    assign w_start    = (r_state == IDLE) && w_acc && w_aligned;
    assign w_misalign = (r_state == IDLE) && w_acc && !w_aligned;
    // Ack has priority: timeout only fires on the last REQ cycle with no ack
    assign w_tmo      = (r_state == REQ) && !mem_ack_i && (r_cnt == TMO_LAST);

    // Pipeline freeze: from the first visible cycle of an access until DONE.
    // Held low during reset so the pipeline is released immediately.
    assign stall_o = !rst_i && (w_start || (r_state == REQ));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE lasts exactly one cycle so the pipeline can
    // advance past the finished instruction before the next one is sampled
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i || w_tmo) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request/result registers; err is a single-cycle pulse by construction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_err <= 1'b0;
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= MemWrite_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_cnt   <= 16'd0;
            end else if (w_misalign) begin
                r_err   <= 1'b1;
                r_rdata <= 32'd0;
            end else if (r_state == REQ) begin
                r_cnt <= r_cnt + 16'd1;
                if (mem_ack_i) begin
                    r_req <= 1'b0;
                    // stores leave the previous load result in place
                    if (!r_we) begin
                        r_rdata <= mem_rdata_i;
                    end
                end else if (w_tmo) begin
                    r_req   <= 1'b0;
                    r_err   <= 1'b1;
                    r_rdata <= 32'd0;
                end
            end
        end
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;

endmodule
